gt_reset_seq: RTL and testbench
===============================

# gt_reset_seq

Parametrised multi-channel transceiver bring-up sequencer, successor to the fixed 60/120-cycle CPLL reset counter in the K7 GTX Ethernet top. Per channel, it pulses the CPLL reset and waits for lock. It then asserts the GT TX/RX reset and waits for user-clock MMCM lock and GT resetdone before declaring the link usable. Beyond the old counter, it adds lock timeouts, bounded retries, per-channel soft reset and run-time loss-of-lock recovery. It sits in the `drp_clk` domain between board reset and the `gtx_wrap`/`gtp_usrclk` instances.

## Interface
- `N_CH`, 4: number of transceiver channels.
- `PWR_DELAY`, 60: cycles after reset release before the first CPLL reset.
- `PLL_RST_LEN`, 4: CPLL reset pulse width, in cycles.
- `LOCK_TIMEOUT`, 120: cycles allowed for CPLL lock or for usr/resetdone.
- `GT_RST_LEN`, 8: GT reset pulse width, in cycles.
- `MAX_RETRY`, 7: retries before fault; range 1..15.

Ports:
- `drp_clk`, in, 1: the only clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `soft_reset`, in, N_CH: per-channel restart request, edge-detected on the rising edge.
- `pll_locked`, in, N_CH: CPLL lock; asynchronous.
- `usrclk_rdy`, in, N_CH: user-clock MMCM lock; asynchronous.
- `resetdone`, in, N_CH: GT TX&RX resetdone; asynchronous.
- `cpll_reset`, out, N_CH: CPLL reset.
- `gt_reset`, out, N_CH: GT TX/RX reset.
- `ready`, out, N_CH: channel in RUN.
- `all_ready`, out, 1: AND of `ready`.
- `fault`, out, N_CH: retries exhausted.
- `retry_cnt`, out, 4*N_CH: saturating retry count per channel; channel k occupies bits [4k+3:4k].

## Operation
- All async inputs pass through a 2-FF synchroniser; below, "lock" always means the synchronised value.
- Per-channel FSM:
  - **PWRUP**: count `PWR_DELAY` cycles, then go to PLLRST.
  - **PLLRST**: `cpll_reset`=1 for `PLL_RST_LEN` cycles, then go to PLLWAIT.
  - **PLLWAIT**: lock → GTRST. Timeout → retry, then PLLRST.
  - **GTRST**: `gt_reset`=1 for `GT_RST_LEN` cycles, then go to USRWAIT.
  - **USRWAIT**: `usrclk_rdy`&`resetdone` → RUN. Timeout → retry, then GTRST. Lock lost → retry, then PLLRST.
  - **RUN**: `ready`=1. Lock lost → PLLRST (counts as a retry). `resetdone` lost → GTRST (counts as a retry).
  - **FAULT**: `fault`=1, all drives low, held. Exits only on reset or a `soft_reset` edge.
- Retry rule: on a retry, the count increments, saturating at 15. If the count before the increment equals `MAX_RETRY`, go to FAULT instead.
- Entering RUN clears the retry counter.
- `soft_reset` rising edge, in any state: go to GTRST, unless lock is low, in which case go to PLLRST. Retry counter clears. It is not counted as a retry.
- Simultaneous events: `soft_reset` edge beats timeout, and timeout beats lock loss.
- Channels are fully independent; only PWRUP timing is common.

## Timing
- Reset values: `cpll_reset`=0, `gt_reset`=0, `ready`=0, `all_ready`=0, `fault`=0, `retry_cnt`=0. FSM in PWRUP, counter 0.
- `reset_n` assertion mid-sequence drops all outputs immediately (asynchronous). Deassertion restarts from PWRUP.
- All outputs are registered and change on the `drp_clk` edge after the state change.
- `cpll_reset` goes high at cycle `PWR_DELAY`+1 after reset release and stays high exactly `PLL_RST_LEN` cycles.
- Input-to-action latency is 3 cycles: 2 synchroniser stages plus the FSM register. The timeout counter starts on the cycle of state entry.
- Counter width is `$clog2(max(all delays)+1)`. The counter reloads on every state entry and never wraps.

## Configuration
- `GT_RESET_SEQ_WATCHDOG_EN` defined: timeouts, retry counting, FAULT and RUN-state loss monitoring are active as described above.
- Not defined: PLLWAIT and USRWAIT wait indefinitely, and RUN ignores lock/resetdone loss. `fault` and `retry_cnt` are tied to 0; `soft_reset` still works.

## Structure
- Package `gt_reset_pkg`: the state enum (PWRUP, PLLRST, PLLWAIT, GTRST, USRWAIT, RUN, FAULT) and the `RETRY_W`=4 constant.
- Sub-module `gt_reset_ch`: one channel's synchroniser, FSM, counter and retry logic. The top generates `N_CH` instances and forms `all_ready`.

## Test plan
Bench parameters: `N_CH`=2, `PWR_DELAY`=10, `PLL_RST_LEN`=4, `LOCK_TIMEOUT`=20, `GT_RST_LEN`=8, `MAX_RETRY`=3, with the macro defined.
1. Locks arrive 5 cycles after `cpll_reset` falls; `usrclk_rdy`/`resetdone` arrive 5 cycles after `gt_reset` falls → `cpll_reset` high cycles 11–14, `ready`=1 on both channels, `all_ready`=1, `retry_cnt`=0.
2. `pll_locked[1]` held low → 3 retries (`retry_cnt[7:4]` reaches 3), then `fault[1]`=1 and `cpll_reset[1]` stays low. Channel 0 reaches `ready`.
3. In RUN, drop `pll_locked[0]` for 1 cycle → 3 cycles later `ready[0]`=0 and `cpll_reset[0]` pulses for 4 cycles. After relock, RUN is re-entered and `retry_cnt[3:0]` returns to 0.
4. `soft_reset[1]` edge while in FAULT with lock high → GTRST, `gt_reset[1]` high for 8 cycles, `fault[1]`=0, `retry_cnt[7:4]`=0.
5. Assert `reset_n`=0 during GTRST → `gt_reset`=0 immediately, without waiting for a clock edge. After release, PWRUP counts 10 cycles again.
6. Without the macro and `pll_locked` held low for 1000 cycles → no retry and `fault`=0. Raising lock then completes bring-up normally.

Source files
------------

// File: rtl/gt_reset_pkg.sv
// Shared types and constants for the transceiver bring-up sequencer.
package gt_reset_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PWRUP,
        PLLRST,
        PLLWAIT,
        GTRST,
        USRWAIT,
        RUN,
        FAULT
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/gt_reset_ch.sv
// One transceiver channel: input synchronisers, bring-up FSM, delay counter and retry logic.
// GT_RESET_SEQ_WATCHDOG_EN enables timeouts, retries, FAULT and run-time loss monitoring.
module gt_reset_ch
    import gt_reset_pkg::*;
#(
    parameter int PWR_DELAY    = 60,
    parameter int PLL_RST_LEN  = 4,
    parameter int LOCK_TIMEOUT = 120,
    parameter int GT_RST_LEN   = 8,
    parameter int MAX_RETRY    = 7
) (
    input  logic               drp_clk,
    input  logic               reset_n,
    input  logic               soft_reset,
    input  logic               pll_locked,
    input  logic               usrclk_rdy,
    input  logic               resetdone,
    output logic               cpll_reset,
    output logic               gt_reset,
    output logic               ready,
    output logic               running,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt
);

`ifdef GT_RESET_SEQ_WATCHDOG_EN
    localparam bit WATCHDOG = 1'b1;
`else
    localparam bit WATCHDOG = 1'b0;
`endif

    localparam int CNT_MAX = max_int(max_int(PWR_DELAY, PLL_RST_LEN),
                                     max_int(LOCK_TIMEOUT, GT_RST_LEN));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   PWR_LAST = CNT_W'(PWR_DELAY - 1);
    localparam logic [CNT_W-1:0]   PLL_LAST = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   GT_LAST  = CNT_W'(GT_RST_LEN - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [3:0] meta;
    logic [3:0] sync;
    logic       soft_q;
    logic       soft_lvl, lock, usr_rdy, done, soft_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge drp_clk or negedge reset_n) begin
        if (!reset_n) begin
            meta   <= '0;
            sync   <= '0;
            soft_q <= 1'b0;
        end else begin
            meta   <= {soft_reset, pll_locked, usrclk_rdy, resetdone};
            sync   <= meta;
            soft_q <= sync[3];
        end
    end

    assign {soft_lvl, lock, usr_rdy, done} = sync;
    assign soft_edge = soft_lvl & ~soft_q;

    state_t             state, state_n, retry_tgt;
    logic [CNT_W-1:0]   cnt;
    logic [RETRY_W-1:0] retry, retry_n;
    logic               do_retry, enter;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_n   = state;
        retry_n   = retry;
        do_retry  = 1'b0;
        retry_tgt = state;

        case (state)
            PWRUP:   if (cnt == PWR_LAST) state_n = PLLRST;
            PLLRST:  if (cnt == PLL_LAST) state_n = PLLWAIT;
            PLLWAIT: begin
                if (lock) begin
                    state_n = GTRST;
                end else if (WATCHDOG && cnt == TMO_LAST) begin
                    do_retry  = 1'b1;
                    retry_tgt = PLLRST;
                end
            end
            GTRST:   if (cnt == GT_LAST) state_n = USRWAIT;
            USRWAIT: begin
                if (lock && usr_rdy && done) begin
                    state_n = RUN;
                end else if (WATCHDOG && cnt == TMO_LAST) begin
                    do_retry  = 1'b1;
                    retry_tgt = GTRST;
                end else if (WATCHDOG && !lock) begin
                    do_retry  = 1'b1;
                    retry_tgt = PLLRST;
                end
            end
            RUN: begin
                if (WATCHDOG && !lock) begin
                    do_retry  = 1'b1;
                    retry_tgt = PLLRST;
                end else if (WATCHDOG && !done) begin
                    do_retry  = 1'b1;
                    retry_tgt = GTRST;
                end
            end
            default: state_n = state;
        endcase

        // The count that hits the limit sends the channel to FAULT without incrementing.
        if (do_retry) begin
            if (retry == RETRY_LIMIT) begin
                state_n = FAULT;
            end else begin
                state_n = retry_tgt;
                if (retry != '1) retry_n = retry + 1'b1;
            end
        end

        if (state_n == RUN && state != RUN) retry_n = '0;

        if (soft_edge) begin
            state_n = lock ? GTRST : PLLRST;
            retry_n = '0;
        end
    end

    // A soft restart into the current state still counts as a fresh entry.
    assign enter = (state_n != state) || soft_edge;

    always_ff @(posedge drp_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= PWRUP;
            cnt   <= '0;
            retry <= '0;
        end else begin
            state <= state_n;
            retry <= retry_n;
            if (enter)
                cnt <= '0;
            else if (cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign running = (state == RUN);

    always_ff @(posedge drp_clk or negedge reset_n) begin
        if (!reset_n) begin
            cpll_reset <= 1'b0;
            gt_reset   <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            cpll_reset <= (state == PLLRST);
            gt_reset   <= (state == GTRST);
            ready      <= (state == RUN);
            fault      <= WATCHDOG && (state == FAULT);
            retry_cnt  <= WATCHDOG ? retry : '0;
        end
    end

endmodule

// File: rtl/gt_reset_seq.sv
// Multi-channel transceiver bring-up sequencer: one independent gt_reset_ch per channel
// plus the registered all-channels-ready flag.
module gt_reset_seq
    import gt_reset_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int PWR_DELAY    = 60,
    parameter int PLL_RST_LEN  = 4,
    parameter int LOCK_TIMEOUT = 120,
    parameter int GT_RST_LEN   = 8,
    parameter int MAX_RETRY    = 7
) (
    input  logic                      drp_clk,
    input  logic                      reset_n,
    input  logic [N_CH-1:0]           soft_reset,
    input  logic [N_CH-1:0]           pll_locked,
    input  logic [N_CH-1:0]           usrclk_rdy,
    input  logic [N_CH-1:0]           resetdone,
    output logic [N_CH-1:0]           cpll_reset,
    output logic [N_CH-1:0]           gt_reset,
    output logic [N_CH-1:0]           ready,
    output logic                      all_ready,
    output logic [N_CH-1:0]           fault,
    output logic [RETRY_W*N_CH-1:0]   retry_cnt
);

    logic [N_CH-1:0] running;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        gt_reset_ch #(
            .PWR_DELAY    (PWR_DELAY),
            .PLL_RST_LEN  (PLL_RST_LEN),
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .GT_RST_LEN   (GT_RST_LEN),
            .MAX_RETRY    (MAX_RETRY)
        ) u_ch (
            .drp_clk    (drp_clk),
            .reset_n    (reset_n),
            .soft_reset (soft_reset[k]),
            .pll_locked (pll_locked[k]),
            .usrclk_rdy (usrclk_rdy[k]),
            .resetdone  (resetdone[k]),
            .cpll_reset (cpll_reset[k]),
            .gt_reset   (gt_reset[k]),
            .ready      (ready[k]),
            .running    (running[k]),
            .fault      (fault[k]),
            .retry_cnt  (retry_cnt[RETRY_W*k +: RETRY_W])
        );
    end

    // Registered from the channel states so it lines up with the per-channel ready flops.
    always_ff @(posedge drp_clk or negedge reset_n) begin
        if (!reset_n)
            all_ready <= 1'b0;
        else
            all_ready <= &running;
    end

endmodule

// File: tb/tb_gt_reset_seq.sv
// Bench for gt_reset_seq: a behavioural GT model answers the reset pulses, and a pulse-width
// scoreboard checks every cpll_reset/gt_reset pulse against the widths queued by the stimulus.
`timescale 1ns/1ps
module tb_gt_reset_seq;

    localparam int N_CH         = 2;
    localparam int PWR_DELAY    = 10;
    localparam int PLL_RST_LEN  = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int GT_RST_LEN   = 8;
    localparam int MAX_RETRY    = 3;

    localparam int S_CPLL = 0, S_GT = 1, S_READY = 2, S_FAULT = 3, S_ALL = 4;

    logic                drp_clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [N_CH-1:0]     soft_reset = '0;
    logic [N_CH-1:0]     pll_locked = '0;
    logic [N_CH-1:0]     usrclk_rdy = '0;
    logic [N_CH-1:0]     resetdone  = '0;
    logic [N_CH-1:0]     cpll_reset, gt_reset, ready, fault;
    logic                all_ready;
    logic [4*N_CH-1:0]   retry_cnt;

    gt_reset_seq #(
        .N_CH(N_CH), .PWR_DELAY(PWR_DELAY), .PLL_RST_LEN(PLL_RST_LEN),
        .LOCK_TIMEOUT(LOCK_TIMEOUT), .GT_RST_LEN(GT_RST_LEN), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .drp_clk(drp_clk), .reset_n(reset_n), .soft_reset(soft_reset),
        .pll_locked(pll_locked), .usrclk_rdy(usrclk_rdy), .resetdone(resetdone),
        .cpll_reset(cpll_reset), .gt_reset(gt_reset), .ready(ready),
        .all_ready(all_ready), .fault(fault), .retry_cnt(retry_cnt)
    );

    always #5 drp_clk = ~drp_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- pulse-width scoreboard ----------------
    typedef struct {
        int ch;
        bit is_gt;
        int width;
    } exp_t;
    exp_t exp_q[$];

    task automatic expect_pulse(input int ch, input bit is_gt, input int width);
        exp_t e;
        e.ch = ch; e.is_gt = is_gt; e.width = width;
        exp_q.push_back(e);
    endtask

    task automatic score(input int ch, input bit is_gt, input int w);
        int    idx = -1;
        string tag = $sformatf("%s[%0d] pulse width", is_gt ? "gt_reset" : "cpll_reset", ch);
        foreach (exp_q[i])
            if (idx < 0 && exp_q[i].ch == ch && exp_q[i].is_gt == is_gt) idx = i;
        if (idx >= 0) begin
            check(tag, w, exp_q[idx].width);
            exp_q.delete(idx);
        end else begin
            check({tag, " (unexpected pulse)"}, w, 0);
        end
    endtask

    initial begin
        int wc[N_CH];
        int wg[N_CH];
        foreach (wc[i]) begin wc[i] = 0; wg[i] = 0; end
        forever begin
            @(posedge drp_clk); #1;
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!reset_n) begin
                    wc[ch] = 0; wg[ch] = 0;
                end else begin
                    if (cpll_reset[ch]) wc[ch]++;
                    else if (wc[ch] > 0) begin score(ch, 1'b0, wc[ch]); wc[ch] = 0; end
                    if (gt_reset[ch]) wg[ch]++;
                    else if (wg[ch] > 0) begin score(ch, 1'b1, wg[ch]); wg[ch] = 0; end
                end
            end
        end
    end

    // ---------------- behavioural GT model ----------------
    logic [N_CH-1:0] lock_en     = '1;
    logic [N_CH-1:0] lock_glitch = '0;
    logic [N_CH-1:0] pll_armed   = '0;
    logic [N_CH-1:0] gt_armed    = '0;
    int lock_dly[N_CH];
    int usr_dly[N_CH];

    initial begin
        foreach (lock_dly[i]) begin lock_dly[i] = 0; usr_dly[i] = 0; end
        forever begin
            @(negedge drp_clk);
            for (int ch = 0; ch < N_CH; ch++) begin
                if (!reset_n) begin
                    pll_armed[ch] = 1'b0; gt_armed[ch] = 1'b0;
                    lock_dly[ch] = 0; usr_dly[ch] = 0;
                end else begin
                    if (cpll_reset[ch]) begin
                        pll_armed[ch] = 1'b1; lock_dly[ch] = 0; usr_dly[ch] = 0;
                    end else if (lock_dly[ch] < 5) begin
                        lock_dly[ch]++;
                    end
                    if (gt_reset[ch]) begin
                        gt_armed[ch] = 1'b1; usr_dly[ch] = 0;
                    end else if (!cpll_reset[ch] && usr_dly[ch] < 5) begin
                        usr_dly[ch]++;
                    end
                end
                pll_locked[ch] = lock_en[ch] && pll_armed[ch] && lock_dly[ch] >= 5 && !lock_glitch[ch];
                usrclk_rdy[ch] = gt_armed[ch] && usr_dly[ch] >= 5;
                resetdone[ch]  = gt_armed[ch] && usr_dly[ch] >= 5;
            end
        end
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int which, input int ch);
        case (which)
            S_CPLL:  return cpll_reset[ch];
            S_GT:    return gt_reset[ch];
            S_READY: return ready[ch];
            S_FAULT: return fault[ch];
            default: return all_ready;
        endcase
    endfunction

    task automatic cycles(input int n);
        repeat (n) begin @(posedge drp_clk); #1; end
    endtask

    task automatic wait_until(input string tag, input int which, input int ch,
                              input logic val, input int budget);
        int n = 0;
        while (sig(which, ch) !== val && n < budget) begin
            @(posedge drp_clk); #1;
            n++;
        end
        check({tag, " (bounded wait)"}, sig(which, ch), val);
    endtask

    task automatic pulse_soft(input int ch);
        soft_reset[ch] = 1'b1;
        cycles(3);
        soft_reset[ch] = 1'b0;
    endtask

    task automatic expect_bringup(input int ch);
        expect_pulse(ch, 1'b0, PLL_RST_LEN);
        expect_pulse(ch, 1'b1, GT_RST_LEN);
    endtask

    // Called right after reset release (on a falling edge): cpll_reset must be high
    // for edges PWR_DELAY+1 .. PWR_DELAY+PLL_RST_LEN only.
    task automatic check_pwrup(input string tag);
        for (int c = 1; c <= PWR_DELAY + PLL_RST_LEN + 2; c++) begin
            @(posedge drp_clk); #1;
            for (int ch = 0; ch < N_CH; ch++)
                check($sformatf("%s cpll_reset[%0d] cycle %0d", tag, ch, c), cpll_reset[ch],
                      (c >= PWR_DELAY + 1 && c <= PWR_DELAY + PLL_RST_LEN));
        end
    endtask

    task automatic do_reset();
        @(negedge drp_clk);
        reset_n = 1'b0;
        repeat (3) @(negedge drp_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL global time limit reached");
        $fatal(1, "bench time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge drp_clk);
        check("reset cpll_reset", cpll_reset, 0);
        check("reset gt_reset",   gt_reset,   0);
        check("reset ready",      ready,      0);
        check("reset all_ready",  all_ready,  0);
        check("reset fault",      fault,      0);
        check("reset retry_cnt",  retry_cnt,  0);

        // 1: clean bring-up on both channels
        expect_bringup(0);
        expect_bringup(1);
        reset_n = 1'b1;
        check_pwrup("t1");
        wait_until("t1 all_ready", S_ALL, 0, 1'b1, 200);
        check("t1 ready",     ready,     2'b11);
        check("t1 retry_cnt", retry_cnt, 0);
        check("t1 fault",     fault,     0);
        check("t1 pending pulses", exp_q.size(), 0);

`ifdef GT_RESET_SEQ_WATCHDOG_EN
        // 3: one-cycle lock loss in RUN restarts the channel from PLLRST
        expect_bringup(0);
        lock_glitch[0] = 1'b1;
        cycles(1);
        lock_glitch[0] = 1'b0;
        wait_until("t3 cpll_reset[0] rises", S_CPLL, 0, 1'b1, 8);
        check("t3 ready[0] dropped",   ready[0],      0);
        check("t3 all_ready dropped",  all_ready,     0);
        check("t3 retry_cnt[3:0]",     retry_cnt[3:0], 1);
        wait_until("t3 ready[0] back", S_READY, 0, 1'b1, 200);
        check("t3 retry_cnt[3:0] cleared", retry_cnt[3:0], 0);
        check("t3 all_ready back",     all_ready,     1);
        check("t3 pending pulses", exp_q.size(), 0);

        // 2: channel 1 never locks -> retries exhausted -> FAULT
        expect_bringup(0);
        for (int i = 0; i <= MAX_RETRY; i++) expect_pulse(1, 1'b0, PLL_RST_LEN);
        lock_en = 2'b01;
        do_reset();
        wait_until("t2 fault[1]", S_FAULT, 1, 1'b1, 400);
        check("t2 retry_cnt[7:4]", retry_cnt[7:4], MAX_RETRY);
        check("t2 cpll_reset[1]",  cpll_reset[1],  0);
        check("t2 ready[1]",       ready[1],       0);
        cycles(30);
        check("t2 fault[1] held",      fault[1],      1);
        check("t2 cpll_reset[1] low",  cpll_reset[1], 0);
        check("t2 ready[0]",           ready[0],      1);
        check("t2 all_ready",          all_ready,     0);
        check("t2 pending pulses", exp_q.size(), 0);

        // 4: soft reset out of FAULT with lock high goes straight to GTRST
        lock_en[1] = 1'b1;
        expect_pulse(1, 1'b1, GT_RST_LEN);
        cycles(5);
        pulse_soft(1);
        wait_until("t4 gt_reset[1]", S_GT, 1, 1'b1, 8);
        check("t4 fault[1] cleared", fault[1],       0);
        check("t4 retry_cnt[7:4]",   retry_cnt[7:4], 0);
        check("t4 cpll_reset[1]",    cpll_reset[1],  0);
        wait_until("t4 ready[1]", S_READY, 1, 1'b1, 200);
        check("t4 all_ready", all_ready, 1);
        check("t4 pending pulses", exp_q.size(), 0);
`else
        // RUN ignores lock loss without the watchdog
        lock_glitch[0] = 1'b1;
        cycles(1);
        lock_glitch[0] = 1'b0;
        cycles(10);
        check("t3 ready[0] kept",     ready[0],      1);
        check("t3 cpll_reset[0] low", cpll_reset[0], 0);
        check("t3 retry_cnt",         retry_cnt,     0);

        // 6: channel 1 waits for lock indefinitely, no retry, no fault
        expect_bringup(0);
        expect_pulse(1, 1'b0, PLL_RST_LEN);
        lock_en = 2'b01;
        do_reset();
        wait_until("t6 ready[0]", S_READY, 0, 1'b1, 200);
        cycles(1000);
        check("t6 fault",          fault,         0);
        check("t6 retry_cnt",      retry_cnt,     0);
        check("t6 ready[1]",       ready[1],      0);
        check("t6 cpll_reset[1]",  cpll_reset[1], 0);
        check("t6 gt_reset[1]",    gt_reset[1],   0);
        expect_pulse(1, 1'b1, GT_RST_LEN);
        lock_en[1] = 1'b1;
        wait_until("t6 ready[1]", S_READY, 1, 1'b1, 200);
        check("t6 all_ready", all_ready, 1);
        check("t6 pending pulses", exp_q.size(), 0);

        // soft reset still restarts a running channel at GTRST
        expect_pulse(1, 1'b1, GT_RST_LEN);
        pulse_soft(1);
        wait_until("t4 gt_reset[1]", S_GT, 1, 1'b1, 8);
        check("t4 ready[1] dropped", ready[1],      0);
        check("t4 cpll_reset[1]",    cpll_reset[1], 0);
        wait_until("t4 ready[1]", S_READY, 1, 1'b1, 200);
        check("t4 pending pulses", exp_q.size(), 0);
`endif

        // 5: asynchronous reset in the middle of GTRST
        pulse_soft(0);
        wait_until("t5 gt_reset[0]", S_GT, 0, 1'b1, 8);
        cycles(2);
        check("t5 gt_reset[0] before reset", gt_reset[0], 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5 gt_reset async drop", gt_reset,  0);
        check("t5 ready async drop",    ready,     0);
        check("t5 all_ready async drop", all_ready, 0);
        check("t5 retry_cnt in reset",  retry_cnt, 0);
        lock_en = '1;
        expect_bringup(0);
        expect_bringup(1);
        repeat (3) @(negedge drp_clk);
        reset_n = 1'b1;
        check_pwrup("t5");
        wait_until("t5 all_ready", S_ALL, 0, 1'b1, 300);
        check("t5 fault", fault, 0);
        check("t5 pending pulses", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
